shifter_bus_sequencer: RTL and testbench
========================================

Name: shifter_bus_sequencer

Overview:
Sequences the shifter's bus from the 32 MHz domain. Generates raster timing (h/v counters, sync, de) and issues one /LOAD per 16-clock word slot inside the display window, feeding words fetched from video RAM. Arbitrates CPU palette/resolution register accesses (cs_n/rw/addr) into a fixed slot phase that never collides with loads. Sits between the video fetch path, the CPU bus interface and the shifter.

Parameters:
H_TOTAL, 2048, clocks per line; multiple of 16
H_DE_START, 448, first de clock in a line; multiple of 16
H_DE_WORDS, 80, load slots (words) per active line
V_TOTAL, 313, lines per frame
V_DE_START, 63, first active line
V_DE_LINES, 200, active lines per frame
HSYNC_LEN, 150, hsync_n low clocks from h=0
VSYNC_LINES, 3, vsync_n low lines from v=0
LOAD_PHASE, 12, slot phase where load_n falls; legal 4..12

Ports:
CLOCK_32  in  1  32 MHz clock
reset_n  in  1  asynchronous active-low reset
de  out  1  display enable to shifter
load_n  out  1  shifter load strobe, active low
cs_n  out  1  shifter register select, active low
rw  out  1  1=read, 0=write
addr  out  5  shifter register address
sh_wdata  out  16  data driven toward shifter
sh_wdata_oe  out  1  sh_wdata drive enable
sh_rdata  in  16  read data from shifter
hsync_n  out  1  horizontal sync
vsync_n  out  1  vertical sync
vid_req  out  1  one-clock pulse: fetch next video word
vid_word  in  16  fetched video word
vid_valid  in  1  vid_word valid this clock
cpu_req  in  1  CPU register access request (level)
cpu_rw  in  1  1=read
cpu_addr  in  5  register address
cpu_wdata  in  16  write data
cpu_rdata  out  16  read data, valid with cpu_ack
cpu_ack  out  1  one-clock completion pulse
underrun  out  1  sticky: a load had no valid word
underrun_clr  in  1  clears underrun

Behaviour:
- Reset: h=v=0, FSM IDLE; de=0, load_n=1, cs_n=1, rw=1, addr=0, sh_wdata=0, sh_wdata_oe=0, vid_req=0, cpu_ack=0, cpu_rdata=0, hsync_n=1, vsync_n=1, underrun=0. Reset mid-access aborts it with no ack; a still-held cpu_req is served after release.
- h wraps H_TOTAL-1->0 and increments v; v wraps V_TOTAL-1->0. Slot phase p=h[3:0].
- Active slot: v in [V_DE_START, V_DE_START+V_DE_LINES), h in [H_DE_START, H_DE_START+16*H_DE_WORDS). All outputs registered: an event decoded at count h appears at output h+1.
- de=1 exactly over active slots; hsync_n=0 for h<HSYNC_LEN; vsync_n=0 for v<VSYNC_LINES.
- Per active slot: vid_req pulses at p=0. Word latch captures vid_word on any vid_valid with p<LOAD_PHASE; later vid_valid is ignored. load_n=0 for p in LOAD_PHASE..LOAD_PHASE+3, sh_wdata=latched word, sh_wdata_oe=1. If no capture, sh_wdata=0x0000 and underrun sets. Latch clears at p=15.
- underrun_clr has priority over a same-clock set.
- CPU phase CP=(LOAD_PHASE+8) mod 16. FSM: IDLE -(cpu_req)-> SETUP (latch rw/addr/wdata) -(p==CP)-> STROBE (4 clocks: cs_n=0, rw, addr; on write sh_wdata=wdata, oe=1) -> ACK (cpu_ack=1 one clock, cpu_rdata=sh_rdata sampled on last STROBE clock for reads) -> IDLE.
- Max one CPU access per slot. cpu_req high in the clock after ack starts a new access in the next slot. CPU accesses also run outside de.
- Loads and CPU strobes never overlap because CP and LOAD_PHASE are 8 phases apart.

Decomposition:
- Package shifter_bus_pkg: CLKS_PER_ST=4, SLOT_PHASES=16, register address constants (PALETTE_BASE=0, RES_REG=16), CPU FSM state enum.
- Sub-module video_timing_counter: h/v counters, active-window decode, hsync_n/vsync_n, slot phase output.

Test Plan:
Simulation parameters: H_TOTAL=128, H_DE_START=32, H_DE_WORDS=4, V_TOTAL=4, V_DE_START=1, V_DE_LINES=2, HSYNC_LEN=8, VSYNC_LINES=1, LOAD_PHASE=12.
- Timing: release reset -> line 1: de high h=33..96; load_n low h=45-48, 61-64, 77-80, 93-96; lines 0 and 3: no de, no load_n; vsync_n low on line 0 only.
- Fetch: vid_valid with vid_word=0xaaaa at p=2 of each slot -> sh_wdata=0xaaaa, oe=1 during each load_n low; underrun stays 0.
- Underrun: withhold vid_valid in slot 2 -> that load carries 0x0000, underrun=1 until underrun_clr pulse; a same-clock set and clr leaves underrun=0.
- CPU write: cpu_req addr=0xf wdata=0x0fff at h=34 -> cs_n low h=37..40, rw=0, addr=0xf, sh_wdata=0x0fff; cpu_ack at h=41.
- CPU read back-to-back: read addr=16 with sh_rdata=0x0100, cpu_req held -> cpu_rdata=0x0100 with first ack; second strobe starts at p=CP of the next slot.
- Reset mid-strobe: reset_n low during cs_n=0 -> cs_n=1, counters 0, no ack; after release, held cpu_req is served at first p=CP.

Source files
------------

// File: rtl/shifter_bus_pkg.sv
// Shared definitions for the shifter bus sequencer.
//   CLKS_PER_ST  : clocks per shifter strobe (load_n or cs_n low time)
//   SLOT_PHASES  : clocks per word slot
//   PALETTE_BASE : first palette register address
//   RES_REG      : resolution register address
//   cpu_state_e  : CPU register-access FSM states
package shifter_bus_pkg;
  localparam int CLKS_PER_ST = 4;
  localparam int SLOT_PHASES = 16;

  localparam logic [4:0] PALETTE_BASE = 5'd0;
  localparam logic [4:0] RES_REG      = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_ACK    = 2'd3
  } cpu_state_e;
endpackage

// File: rtl/video_timing_counter.sv
// Raster timing: horizontal/vertical counters, active-window decode and
// registered sync outputs.
//   clk, rst_n : clock, asynchronous active-low reset
//   phase      : slot phase, h[3:0] (combinational from the counter)
//   active     : current h/v lies inside the display window (combinational)
//   hsync_n    : low while h < HSYNC_LEN (registered, one clock behind h)
//   vsync_n    : low while v < VSYNC_LINES (registered, one clock behind h)
module video_timing_counter
  import shifter_bus_pkg::*;
#(
  parameter int H_TOTAL     = 2048,
  parameter int H_DE_START  = 448,
  parameter int H_DE_WORDS  = 80,
  parameter int V_TOTAL     = 313,
  parameter int V_DE_START  = 63,
  parameter int V_DE_LINES  = 200,
  parameter int HSYNC_LEN   = 150,
  parameter int VSYNC_LINES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] phase,
  output logic       active,
  output logic       hsync_n,
  output logic       vsync_n
);
  localparam int H_W = $clog2(H_TOTAL);
  localparam int V_W = $clog2(V_TOTAL);
  localparam int HX  = H_W + 1;
  localparam int VX  = V_W + 1;

  // One spare bit so the window end may equal the line/frame length.
  localparam logic [HX-1:0] H_LAST  = HX'(H_TOTAL - 1);
  localparam logic [HX-1:0] H_DE_S  = HX'(H_DE_START);
  localparam logic [HX-1:0] H_DE_E  = HX'(H_DE_START + SLOT_PHASES * H_DE_WORDS);
  localparam logic [HX-1:0] H_SYN_E = HX'(HSYNC_LEN);
  localparam logic [VX-1:0] V_LAST  = VX'(V_TOTAL - 1);
  localparam logic [VX-1:0] V_DE_S  = VX'(V_DE_START);
  localparam logic [VX-1:0] V_DE_E  = VX'(V_DE_START + V_DE_LINES);
  localparam logic [VX-1:0] V_SYN_E = VX'(VSYNC_LINES);

  logic [H_W-1:0] h;
  logic [V_W-1:0] v;
  logic [HX-1:0]  h_x;
  logic [VX-1:0]  v_x;

  assign h_x    = {1'b0, h};
  assign v_x    = {1'b0, v};
  assign phase  = h[3:0];
  assign active = (h_x >= H_DE_S) && (h_x < H_DE_E) &&
                  (v_x >= V_DE_S) && (v_x < V_DE_E);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h       <= '0;
      v       <= '0;
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
    end else begin
      if (h_x == H_LAST) begin
        h <= '0;
        v <= (v_x == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
      hsync_n <= !(h_x < H_SYN_E);
      vsync_n <= !(v_x < V_SYN_E);
    end
  end
endmodule

// File: rtl/shifter_bus_sequencer.sv
// Shifter bus sequencer: raster timing, one shifter load per word slot in
// the display window, and CPU register accesses placed in a fixed slot
// phase half a slot away from the load so the two never collide.
//   CLOCK_32, reset_n          : clock, asynchronous active-low reset
//   de, hsync_n, vsync_n       : raster timing to the shifter
//   load_n, cs_n, rw, addr     : shifter bus control
//   sh_wdata, sh_wdata_oe      : data driven toward the shifter
//   sh_rdata                   : read data from the shifter
//   vid_req/vid_word/vid_valid : video word fetch handshake
//   cpu_req/rw/addr/wdata      : CPU register access request (level)
//   cpu_rdata, cpu_ack         : CPU completion (one-clock ack)
//   underrun, underrun_clr     : sticky missing-word flag and its clear
// All outputs are registered: an event decoded at count h shows at h+1.
module shifter_bus_sequencer
  import shifter_bus_pkg::*;
#(
  parameter int H_TOTAL     = 2048,
  parameter int H_DE_START  = 448,
  parameter int H_DE_WORDS  = 80,
  parameter int V_TOTAL     = 313,
  parameter int V_DE_START  = 63,
  parameter int V_DE_LINES  = 200,
  parameter int HSYNC_LEN   = 150,
  parameter int VSYNC_LINES = 3,
  parameter int LOAD_PHASE  = 12
) (
  input  logic        CLOCK_32,
  input  logic        reset_n,
  output logic        de,
  output logic        load_n,
  output logic        cs_n,
  output logic        rw,
  output logic [4:0]  addr,
  output logic [15:0] sh_wdata,
  output logic        sh_wdata_oe,
  input  logic [15:0] sh_rdata,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        vid_req,
  input  logic [15:0] vid_word,
  input  logic        vid_valid,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [4:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        underrun,
  input  logic        underrun_clr
);
  localparam logic [3:0] LP      = 4'(LOAD_PHASE);
  localparam logic [3:0] LP_LAST = 4'(LOAD_PHASE + CLKS_PER_ST - 1);
  // CPU strobe sits half a slot after the load strobe.
  localparam logic [3:0] CP      = 4'((LOAD_PHASE + SLOT_PHASES / 2) % SLOT_PHASES);
  localparam logic [1:0] CNT_LST = 2'(CLKS_PER_ST - 1);

  logic [3:0]  phase;
  logic        active;
  logic        load_win;
  logic        load_start;

  logic [15:0] word_q;
  logic        word_vld;

  cpu_state_e  state, state_nx;
  logic [1:0]  st_cnt;
  logic        strobe_nx;
  logic        ack_nx;
  logic        rdata_take;
  logic        req_rw;
  logic [4:0]  req_addr;
  logic [15:0] req_wdata;

  logic [15:0] wdata_nx;
  logic        oe_nx;

  video_timing_counter #(
    .H_TOTAL    (H_TOTAL),
    .H_DE_START (H_DE_START),
    .H_DE_WORDS (H_DE_WORDS),
    .V_TOTAL    (V_TOTAL),
    .V_DE_START (V_DE_START),
    .V_DE_LINES (V_DE_LINES),
    .HSYNC_LEN  (HSYNC_LEN),
    .VSYNC_LINES(VSYNC_LINES)
  ) u_timing (
    .clk    (CLOCK_32),
    .rst_n  (reset_n),
    .phase  (phase),
    .active (active),
    .hsync_n(hsync_n),
    .vsync_n(vsync_n)
  );

  assign load_win   = active && (phase >= LP) && (phase <= LP_LAST);
  assign load_start = active && (phase == LP);

  always_comb begin
    state_nx   = state;
    strobe_nx  = 1'b0;
    ack_nx     = 1'b0;
    rdata_take = 1'b0;
    case (state)
      ST_IDLE:   if (cpu_req) state_nx = ST_SETUP;
      ST_SETUP:  if (phase == CP) begin
                   state_nx  = ST_STROBE;
                   strobe_nx = 1'b1;
                 end
      ST_STROBE: if (st_cnt == CNT_LST) begin
                   state_nx   = ST_ACK;
                   ack_nx     = 1'b1;
                   rdata_take = req_rw;
                 end else begin
                   strobe_nx = 1'b1;
                 end
      ST_ACK:    state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Loads and CPU writes never coincide, so a plain priority mux suffices.
  always_comb begin
    wdata_nx = '0;
    oe_nx    = 1'b0;
    if (load_win) begin
      wdata_nx = word_vld ? word_q : '0;
      oe_nx    = 1'b1;
    end else if (strobe_nx && !req_rw) begin
      wdata_nx = req_wdata;
      oe_nx    = 1'b1;
    end
  end

  // Data holding registers: qualified by their valid/state, so no reset.
  always_ff @(posedge CLOCK_32) begin
    if (vid_valid && (phase < LP)) word_q <= vid_word;
    if (state == ST_IDLE && cpu_req) begin
      req_rw    <= cpu_rw;
      req_addr  <= cpu_addr;
      req_wdata <= cpu_wdata;
    end
  end

  always_ff @(posedge CLOCK_32 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      st_cnt      <= '0;
      word_vld    <= 1'b0;
      de          <= 1'b0;
      load_n      <= 1'b1;
      cs_n        <= 1'b1;
      rw          <= 1'b1;
      addr        <= '0;
      sh_wdata    <= '0;
      sh_wdata_oe <= 1'b0;
      vid_req     <= 1'b0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      underrun    <= 1'b0;
    end else begin
      // Word latch: late words (at or after the load phase) are dropped.
      if (phase == 4'hf)                 word_vld <= 1'b0;
      else if (vid_valid && (phase < LP)) word_vld <= 1'b1;

      de          <= active;
      vid_req     <= active && (phase == 4'd0);
      load_n      <= !load_win;
      sh_wdata    <= wdata_nx;
      sh_wdata_oe <= oe_nx;

      if (underrun_clr)                underrun <= 1'b0;
      else if (load_start && !word_vld) underrun <= 1'b1;

      state   <= state_nx;
      st_cnt  <= (state == ST_STROBE) ? st_cnt + 2'd1 : '0;
      cs_n    <= !strobe_nx;
      rw      <= strobe_nx ? req_rw : 1'b1;
      addr    <= strobe_nx ? req_addr : '0;
      cpu_ack <= ack_nx;
      if (rdata_take) cpu_rdata <= sh_rdata;
    end
  end
endmodule

// File: tb/tb_shifter_bus_sequencer.sv
module tb_shifter_bus_sequencer;
  import shifter_bus_pkg::*;

  logic        CLOCK_32;
  logic        reset_n;
  logic        de, load_n, cs_n, rw, sh_wdata_oe;
  logic [4:0]  addr;
  logic [15:0] sh_wdata, sh_rdata;
  logic        hsync_n, vsync_n, vid_req;
  logic [15:0] vid_word;
  logic        vid_valid;
  logic        cpu_req, cpu_rw;
  logic [4:0]  cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_ack, underrun, underrun_clr;

  int n_vec = 0;
  int n_err = 0;

  // Reference raster position: frame, line, clock within line.
  int tf, tv, th;

  shifter_bus_sequencer #(
    .H_TOTAL(128), .H_DE_START(32), .H_DE_WORDS(4), .V_TOTAL(4),
    .V_DE_START(1), .V_DE_LINES(2), .HSYNC_LEN(8), .VSYNC_LINES(1),
    .LOAD_PHASE(12)
  ) dut (
    .CLOCK_32(CLOCK_32), .reset_n(reset_n), .de(de), .load_n(load_n),
    .cs_n(cs_n), .rw(rw), .addr(addr), .sh_wdata(sh_wdata),
    .sh_wdata_oe(sh_wdata_oe), .sh_rdata(sh_rdata), .hsync_n(hsync_n),
    .vsync_n(vsync_n), .vid_req(vid_req), .vid_word(vid_word),
    .vid_valid(vid_valid), .cpu_req(cpu_req), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .underrun(underrun), .underrun_clr(underrun_clr)
  );

  initial CLOCK_32 = 1'b0;
  always #5 CLOCK_32 = ~CLOCK_32;

  always @(posedge CLOCK_32 or negedge reset_n) begin
    if (!reset_n) begin
      tf <= 0; tv <= 0; th <= 0;
    end else if (th == 127) begin
      th <= 0;
      if (tv == 3) begin tv <= 0; tf <= tf + 1; end
      else tv <= tv + 1;
    end else begin
      th <= th + 1;
    end
  end

  // Video feeder: good word at p=2, junk word at p=12 that must be ignored.
  // Frame 0 line 2 slot 2 and frame 1 line 1 slot 1 get no good word.
  initial begin
    logic [2:0] slot;
    logic       skip;
    vid_valid = 1'b0;
    vid_word  = 16'h0000;
    forever begin
      @(negedge CLOCK_32);
      slot = 3'(th / 16) - 3'd2;
      skip = (tf == 0 && tv == 2 && slot == 3'd2) || (tf == 1 && tv == 1 && slot == 3'd1);
      if (th % 16 == 2 && !skip) begin
        vid_valid = 1'b1;
        vid_word  = (tv == 2) ? 16'h5a50 + {13'd0, slot} : 16'haaaa;
      end else if (th % 16 == 12) begin
        vid_valid = 1'b1;
        vid_word  = 16'hdead;
      end else begin
        vid_valid = 1'b0;
        vid_word  = 16'h0000;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_at(input int f, input int v, input int h);
    int n;
    n = 0;
    while (!(tf == f && tv == v && th == h) && n < 3000) begin
      @(negedge CLOCK_32);
      n++;
    end
    if (n >= 3000) begin
      n_vec++;
      n_err++;
      $display("FAIL wait f%0d v%0d h%0d: position not reached in 3000 cycles, required reached", f, v, h);
    end
  endtask

  typedef struct {
    int          f, v, h;
    logic        clr;
    logic        de, load_n, oe;
    logic [15:0] wd;
    logic        hs, vs, req, und;
  } vec_t;

  function automatic vec_t mk(int f, int v, int h, logic clr, logic d, logic ld,
                              logic oe, logic [15:0] wd, logic hs, logic vs,
                              logic rq, logic un);
    vec_t r;
    r.f = f; r.v = v; r.h = h; r.clr = clr; r.de = d; r.load_n = ld; r.oe = oe;
    r.wd = wd; r.hs = hs; r.vs = vs; r.req = rq; r.und = un;
    return r;
  endfunction

  vec_t vecs[29];

  initial begin
    //               f  v   h clr de ld oe  wdata     hs vs rq un
    vecs[0]  = mk(0, 0,   1, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0,   9, 0, 0, 1, 0, 16'h0000, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0,  45, 0, 0, 1, 0, 16'h0000, 1, 0, 0, 0);
    vecs[3]  = mk(0, 1,   1, 0, 0, 1, 0, 16'h0000, 0, 1, 0, 0);
    vecs[4]  = mk(0, 1,  32, 0, 0, 1, 0, 16'h0000, 1, 1, 0, 0);
    vecs[5]  = mk(0, 1,  33, 0, 1, 1, 0, 16'h0000, 1, 1, 1, 0);
    vecs[6]  = mk(0, 1,  34, 0, 1, 1, 0, 16'h0000, 1, 1, 0, 0);
    vecs[7]  = mk(0, 1,  44, 0, 1, 1, 0, 16'h0000, 1, 1, 0, 0);
    vecs[8]  = mk(0, 1,  45, 0, 1, 0, 1, 16'haaaa, 1, 1, 0, 0);
    vecs[9]  = mk(0, 1,  48, 0, 1, 0, 1, 16'haaaa, 1, 1, 0, 0);
    vecs[10] = mk(0, 1,  49, 0, 1, 1, 0, 16'h0000, 1, 1, 1, 0);
    vecs[11] = mk(0, 1,  93, 0, 1, 0, 1, 16'haaaa, 1, 1, 0, 0);
    vecs[12] = mk(0, 1,  96, 0, 1, 0, 1, 16'haaaa, 1, 1, 0, 0);
    vecs[13] = mk(0, 1,  97, 0, 0, 1, 0, 16'h0000, 1, 1, 0, 0);
    vecs[14] = mk(0, 2,  45, 0, 1, 0, 1, 16'h5a50, 1, 1, 0, 0);
    vecs[15] = mk(0, 2,  61, 0, 1, 0, 1, 16'h5a51, 1, 1, 0, 0);
    vecs[16] = mk(0, 2,  76, 0, 1, 1, 0, 16'h0000, 1, 1, 0, 0);
    vecs[17] = mk(0, 2,  77, 0, 1, 0, 1, 16'h0000, 1, 1, 0, 1);
    vecs[18] = mk(0, 2,  80, 0, 1, 0, 1, 16'h0000, 1, 1, 0, 1);
    vecs[19] = mk(0, 2,  93, 0, 1, 0, 1, 16'h5a53, 1, 1, 0, 1);
    vecs[20] = mk(0, 2, 100, 1, 0, 1, 0, 16'h0000, 1, 1, 0, 1);
    vecs[21] = mk(0, 2, 101, 0, 0, 1, 0, 16'h0000, 1, 1, 0, 0);
    vecs[22] = mk(0, 3,  45, 0, 0, 1, 0, 16'h0000, 1, 1, 0, 0);
    vecs[23] = mk(1, 0,   1, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 0);
    vecs[24] = mk(1, 1,  45, 0, 1, 0, 1, 16'haaaa, 1, 1, 0, 0);
    vecs[25] = mk(1, 1,  60, 1, 1, 1, 0, 16'h0000, 1, 1, 0, 0);
    vecs[26] = mk(1, 1,  61, 0, 1, 0, 1, 16'h0000, 1, 1, 0, 0);
    vecs[27] = mk(1, 1,  64, 0, 1, 0, 1, 16'h0000, 1, 1, 0, 0);
    vecs[28] = mk(1, 1,  77, 0, 1, 0, 1, 16'haaaa, 1, 1, 0, 0);

    reset_n = 1'b0; underrun_clr = 1'b0; sh_rdata = 16'h0000;
    cpu_req = 1'b0; cpu_rw = 1'b1; cpu_addr = PALETTE_BASE; cpu_wdata = 16'h0000;

    // Reset state
    repeat (2) @(negedge CLOCK_32);
    check("rst de", {15'd0, de}, 16'd0);
    check("rst load_n", {15'd0, load_n}, 16'd1);
    check("rst cs_n", {15'd0, cs_n}, 16'd1);
    check("rst rw", {15'd0, rw}, 16'd1);
    check("rst addr", {11'd0, addr}, 16'd0);
    check("rst sh_wdata", sh_wdata, 16'h0000);
    check("rst oe", {15'd0, sh_wdata_oe}, 16'd0);
    check("rst vid_req", {15'd0, vid_req}, 16'd0);
    check("rst cpu_ack", {15'd0, cpu_ack}, 16'd0);
    check("rst cpu_rdata", cpu_rdata, 16'h0000);
    check("rst hsync_n", {15'd0, hsync_n}, 16'd1);
    check("rst vsync_n", {15'd0, vsync_n}, 16'd1);
    check("rst underrun", {15'd0, underrun}, 16'd0);
    reset_n = 1'b1;

    // Raster, load and underrun vectors
    for (int i = 0; i < 29; i++) begin
      wait_at(vecs[i].f, vecs[i].v, vecs[i].h);
      check($sformatf("vec%0d de", i), {15'd0, de}, {15'd0, vecs[i].de});
      check($sformatf("vec%0d load_n", i), {15'd0, load_n}, {15'd0, vecs[i].load_n});
      check($sformatf("vec%0d oe", i), {15'd0, sh_wdata_oe}, {15'd0, vecs[i].oe});
      check($sformatf("vec%0d sh_wdata", i), sh_wdata, vecs[i].wd);
      check($sformatf("vec%0d hsync_n", i), {15'd0, hsync_n}, {15'd0, vecs[i].hs});
      check($sformatf("vec%0d vsync_n", i), {15'd0, vsync_n}, {15'd0, vecs[i].vs});
      check($sformatf("vec%0d vid_req", i), {15'd0, vid_req}, {15'd0, vecs[i].req});
      check($sformatf("vec%0d underrun", i), {15'd0, underrun}, {15'd0, vecs[i].und});
      if (vecs[i].clr) begin
        underrun_clr = 1'b1;
        @(negedge CLOCK_32);
        underrun_clr = 1'b0;
      end
    end

    // CPU write, requested at h=34
    wait_at(2, 1, 34);
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 5'h0f; cpu_wdata = 16'h0fff;
    wait_at(2, 1, 35);
    cpu_req = 1'b0;
    for (int h = 36; h <= 42; h++) begin
      logic stb;
      wait_at(2, 1, h);
      stb = (h >= 37 && h <= 40);
      check($sformatf("wr h%0d cs_n", h), {15'd0, cs_n}, {15'd0, !stb});
      check($sformatf("wr h%0d ack", h), {15'd0, cpu_ack}, {15'd0, h == 41});
      check($sformatf("wr h%0d oe", h), {15'd0, sh_wdata_oe}, {15'd0, stb});
      if (stb) begin
        check($sformatf("wr h%0d rw", h), {15'd0, rw}, 16'd0);
        check($sformatf("wr h%0d addr", h), {11'd0, addr}, 16'h000f);
        check($sformatf("wr h%0d sh_wdata", h), sh_wdata, 16'h0fff);
      end
    end

    // Back-to-back CPU reads with cpu_req held
    wait_at(2, 2, 34);
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = RES_REG; sh_rdata = 16'h0100;
    for (int h = 36; h <= 58; h++) begin
      logic stb;
      wait_at(2, 2, h);
      stb = (h >= 37 && h <= 40) || (h >= 53 && h <= 56);
      check($sformatf("rd h%0d cs_n", h), {15'd0, cs_n}, {15'd0, !stb});
      check($sformatf("rd h%0d ack", h), {15'd0, cpu_ack}, {15'd0, h == 41 || h == 57});
      if (stb) begin
        check($sformatf("rd h%0d rw", h), {15'd0, rw}, 16'd1);
        check($sformatf("rd h%0d addr", h), {11'd0, addr}, {11'd0, RES_REG});
        check($sformatf("rd h%0d oe", h), {15'd0, sh_wdata_oe}, 16'd0);
      end
      if (h == 41) begin
        check("rd first rdata", cpu_rdata, 16'h0100);
        sh_rdata = 16'h0200;
      end
      if (h == 43) cpu_req = 1'b0;
      if (h == 57) check("rd second rdata", cpu_rdata, 16'h0200);
    end
    wait_at(2, 2, 69);
    check("rd no third strobe cs_n", {15'd0, cs_n}, 16'd1);
    check("rd rdata held", cpu_rdata, 16'h0200);

    // Reset in the middle of a CPU write strobe
    wait_at(2, 3, 34);
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 5'd5; cpu_wdata = 16'h1234;
    wait_at(2, 3, 38);
    check("mid cs_n before reset", {15'd0, cs_n}, 16'd0);
    reset_n = 1'b0;
    #1;
    check("mid reset cs_n", {15'd0, cs_n}, 16'd1);
    check("mid reset oe", {15'd0, sh_wdata_oe}, 16'd0);
    check("mid reset addr", {11'd0, addr}, 16'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge CLOCK_32);
      check($sformatf("mid reset ack%0d", k), {15'd0, cpu_ack}, 16'd0);
      check($sformatf("mid reset cs_n%0d", k), {15'd0, cs_n}, 16'd1);
    end
    reset_n = 1'b1;
    for (int h = 1; h <= 10; h++) begin
      logic stb;
      wait_at(0, 0, h);
      stb = (h >= 5 && h <= 8);
      if (h == 1) begin
        check("post reset hsync_n", {15'd0, hsync_n}, 16'd0);
        check("post reset vsync_n", {15'd0, vsync_n}, 16'd0);
        cpu_req = 1'b0;
      end
      check($sformatf("post h%0d cs_n", h), {15'd0, cs_n}, {15'd0, !stb});
      check($sformatf("post h%0d ack", h), {15'd0, cpu_ack}, {15'd0, h == 9});
      if (stb) begin
        check($sformatf("post h%0d rw", h), {15'd0, rw}, 16'd0);
        check($sformatf("post h%0d addr", h), {11'd0, addr}, 16'd5);
        check($sformatf("post h%0d sh_wdata", h), sh_wdata, 16'h1234);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
